hansen_dmem_responder: RTL and testbench

- Target (responder) end of the Hansen core data-memory port.
- Serves the core's single-cycle dmem_addr/dmem_wdata/dmem_we/dmem_rdata accesses from on-chip word RAM plus a small MMIO window.
- MMIO window holds: console TX FIFO (valid/ready stream toward a UART), free-running cycle counter, sticky halt/tohost register.
- Sits beside the core in the SoC top; the core has no stall input, so every access completes in its issue cycle.

---
 rtl/hansen_mem_pkg.sv | 30 +++
 rtl/hansen_sync_fifo.sv | 64 ++++++
 rtl/hansen_dmem_responder.sv | 143 ++++++++++++++
 tb/tb_hansen_dmem_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hansen_mem_pkg.sv
// Shared definitions for the Hansen data-memory responder: MMIO offsets,
// STATUS register layout and the address-region predicates.
package hansen_mem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [1:0] OFF_TX_DATA = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_HALT    = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_HALT      = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_W   = 8;

  // Widened compare so RAM_WORDS*4 cannot wrap for large RAMs.
  function automatic logic in_ram(input logic [31:0] addr, input int unsigned ram_words);
    logic [33:0] limit;
    limit = 34'(ram_words) << 2;
    return ({2'b00, addr} < limit);
  endfunction

  function automatic logic in_mmio(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:4] == base[31:4]);
  endfunction

endpackage

// File: rtl/hansen_sync_fifo.sv
// Synchronous FIFO without fall-through; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module hansen_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && (!full_s || do_pop_s);

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/hansen_dmem_responder.sv
// Data-memory responder for the Hansen core: word RAM plus an MMIO window
// with console TX FIFO, cycle counter and sticky halt register.
module hansen_dmem_responder
  import hansen_mem_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  output logic [31:0] dmem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        bus_err
);

  localparam int RAW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]    ram_r [RAM_WORDS];
  logic [31:0]    cycle_r;
  logic           overflow_r;
  logic           halt_r;
  logic [31:0]    halt_code_r;
  logic           bus_err_r;

  logic [RAW-1:0] ram_idx_s;
  logic [1:0]     off_s;
  logic           ram_sel_s;
  logic           mmio_sel_s;
  logic           tx_push_s;
  logic           status_wr_s;
  logic           cycle_wr_s;
  logic           halt_wr_s;
  logic           unmapped_wr_s;
  logic           pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [FCW-1:0] fifo_count_s;
  logic [31:0]    status_s;

  assign ram_idx_s = dmem_addr[RAW+1:2];
  assign off_s     = dmem_addr[3:2];

  // Address decode and store strobes; RAM wins if the regions ever overlap.
  always_comb begin
    ram_sel_s     = in_ram(dmem_addr, RAM_WORDS);
    mmio_sel_s    = !ram_sel_s && in_mmio(dmem_addr, MMIO_BASE);
    tx_push_s     = dmem_we && mmio_sel_s && (off_s == OFF_TX_DATA);
    status_wr_s   = dmem_we && mmio_sel_s && (off_s == OFF_STATUS);
    cycle_wr_s    = dmem_we && mmio_sel_s && (off_s == OFF_CYCLE);
    halt_wr_s     = dmem_we && mmio_sel_s && (off_s == OFF_HALT);
    unmapped_wr_s = dmem_we && !ram_sel_s && !mmio_sel_s;
  end

  assign pop_s    = tx_ready && !fifo_empty_s;
  assign tx_valid = !fifo_empty_s;

  hansen_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tx_push_s),
    .push_data (dmem_wdata[7:0]),
    .pop       (pop_s),
    .head      (tx_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // STATUS register image.
  always_comb begin
    status_s                                = 32'h0000_0000;
    status_s[ST_FULL]                       = fifo_full_s;
    status_s[ST_EMPTY]                      = fifo_empty_s;
    status_s[ST_OVERFLOW]                   = overflow_r;
    status_s[ST_HALT]                       = halt_r;
    status_s[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count_s);
  end

  // Side-effect-free read mux; the core drives ALU results here every cycle.
  always_comb begin
    dmem_rdata = 32'h0000_0000;
    if (ram_sel_s) begin
      dmem_rdata = ram_r[ram_idx_s];
    end else if (mmio_sel_s) begin
      case (off_s)
        OFF_TX_DATA: dmem_rdata = 32'h0000_0000;
        OFF_STATUS:  dmem_rdata = status_s;
        OFF_CYCLE:   dmem_rdata = cycle_r;
        OFF_HALT:    dmem_rdata = halt_code_r;
        default:     dmem_rdata = 32'h0000_0000;
      endcase
    end else begin
      dmem_rdata = 32'h0000_0000;
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (dmem_we && ram_sel_s) begin
      ram_r[ram_idx_s] <= dmem_wdata;
    end
  end

  // MMIO state: cycle counter, overflow, halt and the bus-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_r     <= 32'h0000_0000;
      overflow_r  <= 1'b0;
      halt_r      <= 1'b0;
      halt_code_r <= 32'h0000_0000;
      bus_err_r   <= 1'b0;
    end else begin
      cycle_r   <= cycle_wr_s ? dmem_wdata : (cycle_r + 32'd1);
      bus_err_r <= unmapped_wr_s;
      if (tx_push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else if (status_wr_s && dmem_wdata[ST_OVERFLOW]) begin
        overflow_r <= 1'b0;
      end
      if (halt_wr_s && !halt_r) begin
        halt_r      <= 1'b1;
        halt_code_r <= dmem_wdata;
      end
    end
  end

  assign halt      = halt_r;
  assign halt_code = halt_code_r;
  assign bus_err   = bus_err_r;

endmodule

// File: tb/tb_hansen_dmem_responder.sv
// Scoreboard bench for hansen_dmem_responder: a queue/array reference model
// predicts every cycle's outputs and the byte stream leaving the TX FIFO.
module tb_hansen_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        bus_err;

  localparam logic [31:0] A_TX     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
  localparam logic [31:0] A_HALT   = 32'h8000_000C;

  always #5 clk = ~clk;

  hansen_dmem_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .halt_code  (halt_code),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic        rd_known;
    logic [31:0] rdata;
    logic        tx_valid;
    logic        halt;
    logic [31:0] code;
    logic        berr;
  } exp_t;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [7:0]  mq [$];
  logic        ovf_m;
  logic        halt_m;
  logic [31:0] code_m;
  logic [31:0] cyc_m;
  logic        berr_m;

  exp_t        exp_q [$];
  logic [7:0]  exp_tx [$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:4] == 28'h800_0000;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output logic known);
    logic [31:0] st;
    known = 1'b1;
    st = 32'h0;
    st[0] = (mq.size() == 8);
    st[1] = (mq.size() == 0);
    st[2] = ovf_m;
    st[3] = halt_m;
    st[15:8] = 8'(mq.size());
    if (a < 32'h1000) begin
      known = ram_m.exists(int'(a >> 2));
      return known ? ram_m[int'(a >> 2)] : 32'h0;
    end else if (is_mmio(a)) begin
      case (a[3:2])
        2'd1:    return st;
        2'd2:    return cyc_m;
        2'd3:    return code_m;
        default: return 32'h0;
      endcase
    end else begin
      return 32'h0;
    end
  endfunction

  // Drive one bus cycle, record what the DUT must show, then advance the model.
  task automatic cyc(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic rdy);
    exp_t        e;
    logic        pop;
    logic        push_ok;
    logic [31:0] cnext;
    dmem_addr  = a;
    dmem_we    = we;
    dmem_wdata = wd;
    tx_ready   = rdy;
    e.rdata    = model_read(a, e.rd_known);
    e.tx_valid = (mq.size() != 0);
    e.halt     = halt_m;
    e.code     = code_m;
    e.berr     = berr_m;
    exp_q.push_back(e);
    pop     = (mq.size() != 0) && rdy;
    push_ok = 1'b0;
    cnext   = cyc_m + 32'd1;
    berr_m  = 1'b0;
    if (we) begin
      if (a < 32'h1000) begin
        ram_m[int'(a >> 2)] = wd;
      end else if (is_mmio(a)) begin
        case (a[3:2])
          2'd0: if (mq.size() < 8 || pop) push_ok = 1'b1; else ovf_m = 1'b1;
          2'd1: if (wd[2]) ovf_m = 1'b0;
          2'd2: cnext = wd;
          default: if (!halt_m) begin halt_m = 1'b1; code_m = wd; end
        endcase
      end else begin
        berr_m = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push_ok) begin
      mq.push_back(wd[7:0]);
      exp_tx.push_back(wd[7:0]);
    end
    cyc_m = cnext;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_tx.delete();
    ovf_m  = 1'b0;
    halt_m = 1'b0;
    code_m = 32'h0;
    cyc_m  = 32'h0;
    berr_m = 1'b0;
  endtask

  // Monitor: compare per-cycle outputs and every accepted TX byte.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.rd_known) check("rdata", dmem_rdata, mon_e.rdata);
      check("tx_valid", 32'(tx_valid), 32'(mon_e.tx_valid));
      check("halt", 32'(halt), 32'(mon_e.halt));
      check("halt_code", halt_code, mon_e.code);
      check("bus_err", 32'(bus_err), 32'(mon_e.berr));
    end
    if (reset_n && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
      end else begin
        check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] unm [5];
    logic [31:0] a;
    int          r;
    int          idx;
    logic        we;
    unm = '{32'h0000_1000, 32'h4000_0000, 32'h8000_0010, 32'h7FFF_FFFC, 32'hFFFF_FFFC};

    reset_n    = 1'b0;
    dmem_addr  = A_STATUS;
    dmem_we    = 1'b0;
    dmem_wdata = 32'h0;
    tx_ready   = 1'b0;
    model_reset();
    #3;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
    check("rst_halt_code", halt_code, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_status", dmem_rdata, 32'h0000_0002);
    dmem_addr = A_CYCLE;
    #1;
    check("rst_cycle", dmem_rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Seed the RAM words used by the random phase
    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? 1023 : i;
      cyc(32'(idx * 4), 1'b1, $urandom, 1'b0);
    end

    // RAM write/read-after-write and sub-word addressing
    cyc(32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cyc(32'h10, 1'b0, 32'h0, 1'b0);
    cyc(32'h12, 1'b0, 32'h0, 1'b0);

    // Two bytes, then drain
    cyc(A_TX, 1'b1, 32'h48, 1'b0);
    cyc(A_TX, 1'b1, 32'h69, 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b1);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b1);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);

    // Overflow, clear, push-while-full-with-pop, drain
    for (int i = 1; i <= 9; i++) cyc(A_TX, 1'b1, 32'(i), 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);
    cyc(A_STATUS, 1'b1, 32'h4, 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);
    cyc(A_TX, 1'b1, 32'h0A, 1'b1);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);
    repeat (10) cyc(A_STATUS, 1'b0, 32'h0, 1'b1);

    // Cycle counter load and wrap
    cyc(A_CYCLE, 1'b1, 32'hFFFF_FFFE, 1'b0);
    repeat (3) cyc(A_CYCLE, 1'b0, 32'h0, 1'b0);

    // Sticky halt
    cyc(A_HALT, 1'b1, 32'h1, 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b0);
    cyc(A_HALT, 1'b1, 32'h2, 1'b0);
    cyc(A_HALT, 1'b0, 32'h0, 1'b0);

    // Unmapped stores and the RAM boundary
    cyc(32'h4000_0000, 1'b1, 32'h1234_5678, 1'b0);
    cyc(32'h4000_0000, 1'b0, 32'h0, 1'b0);
    cyc(32'h10, 1'b0, 32'h0, 1'b0);
    cyc(32'h1000, 1'b1, 32'h5555_AAAA, 1'b0);
    cyc(32'hFFC, 1'b0, 32'h0, 1'b0);
    cyc(32'h1000, 1'b0, 32'h0, 1'b0);

    // Queue bytes, start draining, then reset mid-drain with 3 queued
    for (int i = 0; i < 4; i++) cyc(A_TX, 1'b1, 32'(8'h31 + i), 1'b0);
    cyc(A_STATUS, 1'b0, 32'h0, 1'b1);
    dmem_addr = A_STATUS;
    dmem_we   = 1'b0;
    tx_ready  = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'h0);
    check("midrst_status", dmem_rdata, 32'h0000_0002);
    check("midrst_halt", 32'(halt), 32'h0);
    check("midrst_halt_code", halt_code, 32'h0);
    model_reset();
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(32'h10, 1'b0, 32'h0, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: begin
          idx = $urandom_range(0, 16);
          if (idx == 16) idx = 1023;
          a = 32'(idx * 4) | 32'($urandom_range(0, 3));
        end
        4, 5, 6, 7: a = A_TX + 32'($urandom_range(0, 15));
        8:          a = unm[$urandom_range(0, 4)];
        default: begin
          a = $urandom;
          if (a < 32'h1000) a = a | 32'h4000_0000;
        end
      endcase
      we = ($urandom_range(0, 2) == 0);
      if (is_mmio(a) && a[3:2] == 2'd0) we = ($urandom_range(0, 3) != 0);
      cyc(a, we, $urandom, ($urandom_range(0, 2) == 0));
    end

    dmem_we  = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
